// File: rtl/mux8_rr_arb_pkg.sv
// ----------------------------------------------------------------------------
// mux8_arb_pkg
//   Shared constants, FSM state type and the rotate-priority pick function
//   used by the mux8_rr_arb round-robin arbiter.
//   Contents:
//     N_REQ, DW   : number of requesters and data width
//     state_t     : IDLE (nothing held) / HOLD (D_OUT holds a byte)
//     rr_pick()   : returns {found, idx[1:0]} scanning req upward from last+1
// ----------------------------------------------------------------------------
package mux8_arb_pkg;

  localparam int N_REQ = 4;
  localparam int DW    = 8;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  // First set bit of req, starting just after 'last' and wrapping mod 4.
  // 'last' itself is checked last, which is what makes the scheme fair.
  function automatic logic [2:0] rr_pick(input logic [3:0] req,
                                         input logic [1:0] last);
    logic [2:0] r;
    logic [1:0] idx;
    r = 3'b000;
    for (int i = 1; i <= 4; i++) begin
      idx = last + 2'(i);
      if (!r[2] && req[idx]) r = {1'b1, idx};
    end
    return r;
  endfunction

endpackage

// File: rtl/mux8_rr_arb_if.sv
// ----------------------------------------------------------------------------
// mux8_rr_arb_if
//   Bundles the requester side (REQ, LOCK, D_IN0..3) and the downstream
//   valid/ready side (VLD, RDY, D_OUT) plus SEL, GNT and ACK.
//   Modports:
//     master : producers/consumer environment (drives REQ/LOCK/D_IN*/RDY)
//     slave  : the arbiter (drives VLD/D_OUT/SEL/GNT/ACK)
//   Handshake: a byte transfers on every rising edge where VLD=1 and RDY=1.
//   VLD, D_OUT, GNT and SEL never change while VLD=1 and RDY=0; RDY is
//   ignored while VLD=0. ACK marks the transfer edge for the granted source.
// ----------------------------------------------------------------------------
interface mux8_rr_arb_if;
  logic [3:0] REQ;
  logic [3:0] LOCK;
  logic [7:0] D_IN0;
  logic [7:0] D_IN1;
  logic [7:0] D_IN2;
  logic [7:0] D_IN3;
  logic       RDY;
  logic       VLD;
  logic [7:0] D_OUT;
  logic [1:0] SEL;
  logic [3:0] GNT;
  logic [3:0] ACK;

  modport master (
    output REQ, LOCK, D_IN0, D_IN1, D_IN2, D_IN3, RDY,
    input  VLD, D_OUT, SEL, GNT, ACK
  );

  modport slave (
    input  REQ, LOCK, D_IN0, D_IN1, D_IN2, D_IN3, RDY,
    output VLD, D_OUT, SEL, GNT, ACK
  );
endinterface

// File: rtl/mux8_4to1.sv
// ----------------------------------------------------------------------------
// mux8_4to1
//   Plain 8-bit 4-to-1 selector.
//   Ports: SEL[1:0] select, D_IN0..D_IN3[7:0] data, D_OUT[7:0] selected byte.
// ----------------------------------------------------------------------------
module mux8_4to1 (
  input  logic [1:0] SEL,
  input  logic [7:0] D_IN0,
  input  logic [7:0] D_IN1,
  input  logic [7:0] D_IN2,
  input  logic [7:0] D_IN3,
  output logic [7:0] D_OUT
);
  always_comb begin
    D_OUT = D_IN0;
    case (SEL)
      2'd0:    D_OUT = D_IN0;
      2'd1:    D_OUT = D_IN1;
      2'd2:    D_OUT = D_IN2;
      default: D_OUT = D_IN3;
    endcase
  end
endmodule

// File: rtl/mux8_rr_arb_rr_pick4.sv
// ----------------------------------------------------------------------------
// rr_pick4
//   Combinational rotate-priority picker over four request bits.
//   Ports: req[3:0], last[1:0] in; found, idx[1:0] out.
// ----------------------------------------------------------------------------
module rr_pick4
  import mux8_arb_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] last,
  output logic       found,
  output logic [1:0] idx
);
  assign {found, idx} = rr_pick(req, last);
endmodule

// File: rtl/mux8_rr_arb.sv
// ----------------------------------------------------------------------------
// mux8_rr_arb
//   Round-robin arbiter over four byte producers sharing one mux8_4to1.
//   The winner's byte is captured into a registered output with a
//   valid/ready handshake; ACK tells the winner its byte was consumed.
//   Ports:
//     CLK, RST_N : clock, asynchronous active-low reset
//     bus        : mux8_rr_arb_if.slave (REQ, LOCK, D_IN0..3, RDY, VLD,
//                  D_OUT, SEL, GNT, ACK)
//     dbg_state  : current FSM state for observation
//   Parameter RST_LAST: index treated as last granted after reset.
//   Optional feature macro: MUX8_ARB_LOCK_EN -- when defined, a granted
//   requester holding LOCK and REQ is re-granted on its handshake.
//   Without it LOCK is ignored and strict round-robin applies.
// ----------------------------------------------------------------------------
module mux8_rr_arb
  import mux8_arb_pkg::*;
#(
  parameter logic [1:0] RST_LAST = 2'd3
) (
  input  logic                CLK,
  input  logic                RST_N,
  mux8_rr_arb_if.slave        bus,
  output state_t              dbg_state
);

  state_t     state_q, state_d;
  logic [1:0] last_q, last_d;
  logic [1:0] sel_q, sel_d;
  logic [3:0] gnt_q, gnt_d;
  logic       vld_q, vld_d;
  logic [7:0] dout_q, dout_d;

  logic       hs;
  logic       arb_en;
  logic [3:0] req_eff;
  logic       pick_found;
  logic [1:0] pick_idx;
  logic       lock_hit;
  logic       win_valid;
  logic [1:0] win_idx;
  logic [7:0] mux_out;

  assign hs = vld_q & bus.RDY;

  // Arbitration runs when idle, or on the handshake edge while holding.
  // On a handshake the current winner is masked so it is only
  // reconsidered in the following round.
  always_comb begin
    arb_en  = 1'b0;
    req_eff = 4'b0000;
    case (state_q)
      IDLE: begin
        arb_en  = 1'b1;
        req_eff = bus.REQ;
      end
      HOLD: begin
        if (hs) begin
          arb_en  = 1'b1;
          req_eff = bus.REQ & ~gnt_q;
        end
      end
      default: begin
        arb_en  = 1'b0;
        req_eff = 4'b0000;
      end
    endcase
  end

  rr_pick4 u_pick (
    .req   (req_eff),
    .last  (last_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

`ifdef MUX8_ARB_LOCK_EN
  // Locked owner keeps the grant; no state needed since the decision is
  // remade on every handshake from the live LOCK/REQ bits.
  assign lock_hit = (state_q == HOLD) && hs && bus.LOCK[sel_q] && bus.REQ[sel_q];
`else
  logic unused_lock;
  assign unused_lock = ^bus.LOCK;
  assign lock_hit    = 1'b0;
`endif

  assign win_valid = lock_hit | (arb_en & pick_found);
  assign win_idx   = lock_hit ? sel_q : pick_idx;

  // The shared selector is steered by the next-grant index so the winner's
  // byte is available at the capturing edge.
  mux8_4to1 u_mux (
    .SEL   (win_idx),
    .D_IN0 (bus.D_IN0),
    .D_IN1 (bus.D_IN1),
    .D_IN2 (bus.D_IN2),
    .D_IN3 (bus.D_IN3),
    .D_OUT (mux_out)
  );

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    vld_d   = vld_q;
    dout_d  = dout_q;
    if (win_valid) begin
      state_d = HOLD;
      vld_d   = 1'b1;
      dout_d  = mux_out;
      gnt_d   = 4'b0001 << win_idx;
      sel_d   = win_idx;
      // A lock re-grant does not advance the round-robin pointer.
      if (!lock_hit) last_d = win_idx;
    end else if (arb_en) begin
      state_d = IDLE;
      vld_d   = 1'b0;
      gnt_d   = 4'b0000;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      last_q  <= RST_LAST;
      sel_q   <= 2'b00;
      gnt_q   <= 4'b0000;
      vld_q   <= 1'b0;
      dout_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      vld_q   <= vld_d;
      dout_q  <= dout_d;
    end
  end

  assign bus.VLD   = vld_q;
  assign bus.D_OUT = dout_q;
  assign bus.SEL   = sel_q;
  assign bus.GNT   = gnt_q;
  assign bus.ACK   = gnt_q & {4{vld_q & bus.RDY}};
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mux8_rr_arb.sv
// ----------------------------------------------------------------------------
// tb_mux8_rr_arb
//   Directed bench for mux8_rr_arb: reset values, round-robin rotation at
//   full throughput, hold under back-pressure, priority order, reset during
//   a held transfer, and the LOCK behaviour (expectations follow whether
//   MUX8_ARB_LOCK_EN is defined).
// ----------------------------------------------------------------------------
module tb_mux8_rr_arb;
  import mux8_arb_pkg::*;

  logic   CLK;
  logic   RST_N;
  state_t dbg_state;
  int     total;
  int     bad;

  mux8_rr_arb_if bus ();

  mux8_rr_arb #(.RST_LAST(2'd3)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // advance one edge; inputs change and outputs are sampled 1 time unit after
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST_N     = 1'b0;
    bus.REQ   = 4'b0000;
    bus.LOCK  = 4'b0000;
    bus.D_IN0 = 8'h00;
    bus.D_IN1 = 8'h00;
    bus.D_IN2 = 8'h00;
    bus.D_IN3 = 8'h00;
    bus.RDY   = 1'b0;
    #12;
    total++; if (bus.VLD !== 1'b0) begin bad++; $display("FAIL rst_vld got=%b exp=0", bus.VLD); end
    total++; if (bus.D_OUT !== 8'h00) begin bad++; $display("FAIL rst_dout got=%h exp=00", bus.D_OUT); end
    total++; if (bus.GNT !== 4'b0000) begin bad++; $display("FAIL rst_gnt got=%b exp=0000", bus.GNT); end
    total++; if (bus.SEL !== 2'b00) begin bad++; $display("FAIL rst_sel got=%b exp=00", bus.SEL); end
    total++; if (dbg_state !== IDLE) begin bad++; $display("FAIL rst_state got=%b exp=0", dbg_state); end
    step();
    RST_N   = 1'b1;
    bus.RDY = 1'b1;  // RDY while idle must do nothing
    step();
    total++; if (bus.VLD !== 1'b0) begin bad++; $display("FAIL idle_rdy_vld got=%b exp=0", bus.VLD); end
    total++; if (bus.ACK !== 4'b0000) begin bad++; $display("FAIL idle_rdy_ack got=%b exp=0000", bus.ACK); end
  endtask

  task automatic test_rotate();
    logic [7:0] exp_d [5] = '{8'h12, 8'h11, 8'h00, 8'h10, 8'h12};
    logic [3:0] exp_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    bus.D_IN0 = 8'h12;
    bus.D_IN1 = 8'h11;
    bus.D_IN2 = 8'h00;
    bus.D_IN3 = 8'h10;
    bus.RDY   = 1'b1;
    bus.REQ   = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      step();
      total++; if (bus.VLD !== 1'b1) begin bad++; $display("FAIL rot_vld[%0d] got=%b exp=1", i, bus.VLD); end
      total++; if (bus.D_OUT !== exp_d[i]) begin bad++; $display("FAIL rot_dout[%0d] got=%h exp=%h", i, bus.D_OUT, exp_d[i]); end
      total++; if (bus.GNT !== exp_g[i]) begin bad++; $display("FAIL rot_gnt[%0d] got=%b exp=%b", i, bus.GNT, exp_g[i]); end
      total++; if (bus.ACK !== exp_g[i]) begin bad++; $display("FAIL rot_ack[%0d] got=%b exp=%b", i, bus.ACK, exp_g[i]); end
    end
    bus.REQ = 4'b0000;
    step();
    total++; if (bus.VLD !== 1'b0) begin bad++; $display("FAIL rot_end_vld got=%b exp=0", bus.VLD); end
    total++; if (bus.GNT !== 4'b0000) begin bad++; $display("FAIL rot_end_gnt got=%b exp=0000", bus.GNT); end
  endtask

  task automatic test_hold();
    bus.RDY   = 1'b0;
    bus.D_IN2 = 8'hA5;
    bus.REQ   = 4'b0100;
    step();
    for (int i = 0; i < 5; i++) begin
      total++; if (bus.VLD !== 1'b1) begin bad++; $display("FAIL hold_vld[%0d] got=%b exp=1", i, bus.VLD); end
      total++; if (bus.D_OUT !== 8'hA5) begin bad++; $display("FAIL hold_dout[%0d] got=%h exp=a5", i, bus.D_OUT); end
      total++; if (bus.GNT !== 4'b0100) begin bad++; $display("FAIL hold_gnt[%0d] got=%b exp=0100", i, bus.GNT); end
      total++; if (bus.ACK !== 4'b0000) begin bad++; $display("FAIL hold_ack[%0d] got=%b exp=0000", i, bus.ACK); end
      bus.D_IN2 = 8'($urandom_range(0, 255));
      bus.REQ   = 4'($urandom_range(0, 15));
      step();
    end
    bus.REQ = 4'b0000;
    bus.RDY = 1'b1;
    #1;
    total++; if (bus.ACK !== 4'b0100) begin bad++; $display("FAIL hold_hs_ack got=%b exp=0100", bus.ACK); end
    step();
    total++; if (bus.VLD !== 1'b0) begin bad++; $display("FAIL hold_end_vld got=%b exp=0", bus.VLD); end
    total++; if (bus.GNT !== 4'b0000) begin bad++; $display("FAIL hold_end_gnt got=%b exp=0000", bus.GNT); end
    total++; if (bus.ACK !== 4'b0000) begin bad++; $display("FAIL hold_end_ack got=%b exp=0000", bus.ACK); end
    total++; if (bus.SEL !== 2'd2) begin bad++; $display("FAIL hold_end_sel got=%0d exp=2", bus.SEL); end
  endtask

  task automatic test_priority();
    // pointer is at 2; grant 3 first so 3 becomes last granted
    bus.D_IN0 = 8'h30;
    bus.D_IN3 = 8'h33;
    bus.RDY   = 1'b1;
    bus.REQ   = 4'b1000;
    step();
    total++; if (bus.GNT !== 4'b1000) begin bad++; $display("FAIL pri_g3 got=%b exp=1000", bus.GNT); end
    bus.REQ = 4'b1001;
    step();
    total++; if (bus.GNT !== 4'b0001) begin bad++; $display("FAIL pri_g0 got=%b exp=0001", bus.GNT); end
    total++; if (bus.D_OUT !== 8'h30) begin bad++; $display("FAIL pri_d0 got=%h exp=30", bus.D_OUT); end
    step();
    total++; if (bus.GNT !== 4'b1000) begin bad++; $display("FAIL pri_g3b got=%b exp=1000", bus.GNT); end
    total++; if (bus.D_OUT !== 8'h33) begin bad++; $display("FAIL pri_d3b got=%h exp=33", bus.D_OUT); end
    bus.REQ = 4'b0000;
    step();
    total++; if (bus.VLD !== 1'b0) begin bad++; $display("FAIL pri_end_vld got=%b exp=0", bus.VLD); end
  endtask

  task automatic test_reset_mid();
    bus.RDY   = 1'b0;
    bus.D_IN1 = 8'h77;
    bus.REQ   = 4'b0010;
    step();
    total++; if (bus.VLD !== 1'b1) begin bad++; $display("FAIL rm_vld got=%b exp=1", bus.VLD); end
    total++; if (bus.D_OUT !== 8'h77) begin bad++; $display("FAIL rm_dout got=%h exp=77", bus.D_OUT); end
    bus.REQ = 4'b0000;
    RST_N   = 1'b0;
    bus.RDY = 1'b1;
    #1;
    total++; if (bus.VLD !== 1'b0) begin bad++; $display("FAIL rm_async_vld got=%b exp=0", bus.VLD); end
    total++; if (bus.GNT !== 4'b0000) begin bad++; $display("FAIL rm_async_gnt got=%b exp=0000", bus.GNT); end
    total++; if (bus.D_OUT !== 8'h00) begin bad++; $display("FAIL rm_async_dout got=%h exp=00", bus.D_OUT); end
    total++; if (bus.ACK !== 4'b0000) begin bad++; $display("FAIL rm_async_ack got=%b exp=0000", bus.ACK); end
    step();
    RST_N     = 1'b1;
    bus.D_IN0 = 8'h5C;
    bus.D_IN1 = 8'h5D;
    bus.REQ   = 4'b1111;
    step();
    total++; if (bus.GNT !== 4'b0001) begin bad++; $display("FAIL rm_after_gnt got=%b exp=0001", bus.GNT); end
    total++; if (bus.D_OUT !== 8'h5C) begin bad++; $display("FAIL rm_after_dout got=%h exp=5c", bus.D_OUT); end
    bus.REQ = 4'b0000;
    step();
    total++; if (bus.VLD !== 1'b0) begin bad++; $display("FAIL rm_end_vld got=%b exp=0", bus.VLD); end
  endtask

  task automatic test_lock();
`ifdef MUX8_ARB_LOCK_EN
    logic [1:0] exp_i [5] = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd0};
`else
    logic [1:0] exp_i [5] = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd0};
`endif
    logic [3:0] eg;
    logic [7:0] ed;
    RST_N = 1'b0;
    #2;
    RST_N     = 1'b1;
    bus.D_IN0 = 8'hA0;
    bus.D_IN1 = 8'hB1;
    bus.RDY   = 1'b1;
    bus.LOCK  = 4'b0010;
    bus.REQ   = 4'b0011;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) bus.LOCK = 4'b0000;
      step();
      eg = 4'b0001 << exp_i[i];
      ed = (exp_i[i] == 2'd1) ? 8'hB1 : 8'hA0;
      total++; if (bus.GNT !== eg) begin bad++; $display("FAIL lock_gnt[%0d] got=%b exp=%b", i, bus.GNT, eg); end
      total++; if (bus.D_OUT !== ed) begin bad++; $display("FAIL lock_dout[%0d] got=%h exp=%h", i, bus.D_OUT, ed); end
      total++; if (bus.SEL !== exp_i[i]) begin bad++; $display("FAIL lock_sel[%0d] got=%0d exp=%0d", i, bus.SEL, exp_i[i]); end
    end
    bus.REQ  = 4'b0000;
    bus.LOCK = 4'b0000;
    step();
    total++; if (bus.VLD !== 1'b0) begin bad++; $display("FAIL lock_end_vld got=%b exp=0", bus.VLD); end
    total++; if (dbg_state !== IDLE) begin bad++; $display("FAIL lock_end_state got=%b exp=0", dbg_state); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_rotate();
    test_hold();
    test_priority();
    test_reset_mid();
    test_lock();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
